mod10_updown_counter: RTL
=========================

MOD10_UPDOWN_COUNTER -- requirements
Module: mod10_updown_counter

Interface
REQ-001 Parameter: RST_VAL, default 4'd0, data_out value forced by reset; legal range 0..9.
REQ-002 Parameter: WRAP_W, default 8, width of wrap_cnt.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 Port: load  input  1  synchronous load request for data_in.
REQ-006 Port: mode  input  1  count direction; 1 = up, 0 = down.
REQ-007 Port: data_in  input  4  load value; legal 0..9.
REQ-008 Port: data_out  output  4  registered counter value; always 0..9.
REQ-009 Port: tc  output  1  registered terminal-count pulse, one cycle per wrap.
REQ-010 Port: load_err  output  1  registered one-cycle pulse on an illegal load.
REQ-011 Port: wrap_cnt  output  WRAP_W  saturating count of wraps since reset.

Function
REQ-012 The block SHALL implement states CNT (normal) and HOLD (one cycle after an illegal load), registered, with no other states.
REQ-013 In CNT, with load=0 and mode=1, the block SHALL advance data_out by 1 each cycle; 9 SHALL wrap to 0.
REQ-014 In CNT, with load=0 and mode=0, the block SHALL decrement data_out by 1 each cycle; 0 SHALL wrap to 9.
REQ-015 tc SHALL be 1 in exactly the cycle data_out first shows the wrapped value (up 9->0, down 0->9), else 0.
REQ-016 load SHALL take priority over counting; with load=1 and data_in<=9, data_out SHALL equal data_in on the next edge; tc SHALL be 0 that cycle.
REQ-017 With load=1 and data_in>9, the block SHALL keep data_out unchanged, pulse load_err for one cycle and enter HOLD.
REQ-018 In HOLD, the block SHALL keep data_out unchanged for that cycle and return to CNT; a legal load in HOLD SHALL be accepted and SHALL return to CNT.
REQ-019 A mode change SHALL take effect on the same edge it is sampled; there is no turnaround cycle.
REQ-020 Loading 9 with mode=1, or 0 with mode=0, SHALL NOT assert tc; the wrap SHALL occur on the following count edge with tc=1.
REQ-021 Simultaneous load and a wrap condition: load SHALL win; tc=0.
REQ-022 wrap_cnt SHALL increment by 1 on every cycle tc is asserted and SHALL saturate at all-ones.
REQ-023 The counter SHALL compute the next value without intermediate values outside 0..9 appearing on data_out.

Reset
REQ-024 rst=0 SHALL immediately force data_out=RST_VAL, tc=0, load_err=0, wrap_cnt=0 and state CNT, independent of clock.
REQ-025 Reset asserted mid-count or mid-HOLD SHALL abandon the current operation; no pulse SHALL be emitted on release.
REQ-026 On the first rising edge after rst returns to 1, the block SHALL count or load normally.

Configuration
REQ-027 Macro MOD10_WRAP_CNT_EN defined: wrap_cnt SHALL be implemented per REQ-022.
REQ-028 Macro MOD10_WRAP_CNT_EN undefined: wrap_cnt SHALL be tied to 0 with no wrap-count flops; all other behaviour SHALL be unchanged.

Verification
REQ-029 Reset; mode=1, load=0 for 12 cycles -> data_out 1,2,...,9,0,1,2; tc=1 only when data_out=0; wrap_cnt=1.
REQ-030 load=1, data_in=3, mode=0, then load=0 for 5 cycles -> data_out 3,2,1,0,9,8; tc=1 with 9.
REQ-031 load=1, data_in=12 while data_out=5 -> data_out stays 5 for two cycles; load_err=1 for one cycle; counting resumes at 6 (mode=1).
REQ-032 data_out=9, mode=1, load=1 with data_in=4 -> data_out=4, tc=0, wrap_cnt unchanged.
REQ-033 rst=0 between clock edges while data_out=7 -> data_out=RST_VAL (0) without a clock edge; tc, load_err and wrap_cnt are 0.
REQ-034 With MOD10_WRAP_CNT_EN defined, 300 up-wraps (WRAP_W=8) -> wrap_cnt=255; with the macro undefined, wrap_cnt=0 throughout.

Source files
------------

// File: rtl/mod10_updown_counter.sv
// Decimal (0..9) up/down counter with load, illegal-load hold state and wrap pulse.
// Define MOD10_WRAP_CNT_EN to build the saturating wrap counter; otherwise wrap_cnt is tied to 0.
module mod10_updown_counter #(
  parameter logic [3:0] RST_VAL = 4'd0,
  parameter int         WRAP_W  = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load,
  input  logic              mode,
  input  logic [3:0]        data_in,
  output logic [3:0]        data_out,
  output logic              tc,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic {CNT, HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] data_nxt;
  logic       tc_nxt;
  logic       err_nxt;

  // The wrap is decided from the current value, so no out-of-range value is ever formed.
  function automatic logic [3:0] mod10_step(input logic [3:0] v, input logic up);
    if (up) return (v == 4'd9) ? 4'd0 : 4'(v + 4'd1);
    else    return (v == 4'd0) ? 4'd9 : 4'(v - 4'd1);
  endfunction

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    return (&v) ? v : WRAP_W'(v + 1'b1);
  endfunction

  always_comb begin
    state_nxt = CNT;
    data_nxt  = data_out;
    tc_nxt    = 1'b0;
    err_nxt   = 1'b0;
    if (load) begin
      if (data_in <= 4'd9) begin
        data_nxt = data_in;
      end else begin
        err_nxt   = 1'b1;
        state_nxt = HOLD;
      end
    end else if (state == CNT) begin
      data_nxt = mod10_step(data_out, mode);
      tc_nxt   = mode ? (data_out == 4'd9) : (data_out == 4'd0);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= CNT;
      data_out <= RST_VAL;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_out <= data_nxt;
      tc       <= tc_nxt;
      load_err <= err_nxt;
    end
  end

`ifdef MOD10_WRAP_CNT_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)        wrap_cnt <= '0;
    else if (tc_nxt) wrap_cnt <= sat_inc(wrap_cnt);
  end
`else
  assign wrap_cnt = '0;
`endif

endmodule
